// File: rtl/seq_mul64_pkg.sv
// Shared types, widths and carry-lookahead helpers for the seq_mul64 multiplier.
// Pure declarations; no latency or flow-control behaviour of its own.
package seq_mul64_pkg;

    localparam int OP_W      = 64;
    localparam int PROD_W    = 128;
    localparam int ITER_LAST = 63;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry into each of four positions, given per-position propagate/generate and carry-in.
    function automatic logic [3:0] la_carry(input logic [3:0] p, input logic [3:0] g, input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic la_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla128.sv
// 128-bit carry-lookahead adder, three lookahead levels of radix 4 plus a 2-way top.
// Purely combinational; no flow control.
module cla128
    import seq_mul64_pkg::*;
(
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         ci,
    output logic [127:0] s,
    output logic         co
);

    logic [127:0] p, g, c;
    logic [31:0]  p1, g1, c1;
    logic [7:0]   p2, g2, c2;
    logic [1:0]   p3, g3, c3;

    assign p = a ^ b;
    assign g = a & b;

    // Group signals flow upward, carries flow back down each level.
    for (genvar i = 0; i < 32; i++) begin : g_l1
        assign p1[i]        = &p[4*i +: 4];
        assign g1[i]        = la_gen(p[4*i +: 4], g[4*i +: 4]);
        assign c[4*i +: 4]  = la_carry(p[4*i +: 4], g[4*i +: 4], c1[i]);
    end

    for (genvar j = 0; j < 8; j++) begin : g_l2
        assign p2[j]        = &p1[4*j +: 4];
        assign g2[j]        = la_gen(p1[4*j +: 4], g1[4*j +: 4]);
        assign c1[4*j +: 4] = la_carry(p1[4*j +: 4], g1[4*j +: 4], c2[j]);
    end

    for (genvar k = 0; k < 2; k++) begin : g_l3
        assign p3[k]        = &p2[4*k +: 4];
        assign g3[k]        = la_gen(p2[4*k +: 4], g2[4*k +: 4]);
        assign c2[4*k +: 4] = la_carry(p2[4*k +: 4], g2[4*k +: 4], c3[k]);
    end

    assign c3[0] = ci;
    assign c3[1] = g3[0] | (p3[0] & ci);
    assign co    = g3[1] | (p3[1] & c3[1]);
    assign s     = p ^ c;

endmodule

// File: rtl/seq_mul64.sv
// 64x64 unsigned shift-and-add multiplier, one multiplier bit per cycle through one cla128.
// Latency 64 iterations (fewer with EARLY_EXIT); start is ignored while busy, accepted in IDLE or DONE.
module seq_mul64
    import seq_mul64_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [PROD_W-1:0]   result
);

    state_t              state;
    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   acc;
    logic [OP_W-1:0]     mplr;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   sum;
    logic [PROD_W-1:0]   acc_nxt;
    logic                add_co;
    logic                last;

    cla128 u_add (
        .a  (acc),
        .b  (mcand),
        .ci (1'b0),
        .s  (sum),
        .co (add_co)
    );

    assign acc_nxt = mplr[0] ? sum : acc;
    assign last    = (cnt == CNT_W'(ITER_LAST)) ||
                     (EARLY_EXIT && (mplr[OP_W-1:1] == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplr   <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand <= {{(PROD_W-OP_W){1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        result <= acc_nxt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The partial sum is bounded by a*2^(i+1) < 2^128, so the adder can never carry out.
    a_no_carry_out: assert property (@(posedge clk) disable iff (!reset_n) !(busy && add_co));

endmodule
